// File: rtl/z80_io_responder_pkg.sv
// Shared types for the Z80 I/O responder: FSM states, decoded bus-cycle kinds and
// the wait-state limit, plus the pin-level cycle decoder used by the top level.
package z80_resp_pkg;

  typedef enum logic [2:0] {IDLE, WAIT, ACCESS, ACK, HOLD} state_e;

  typedef enum logic [1:0] {CYC_NONE, CYC_RD, CYC_WR, CYC_ACK} cyc_e;

  localparam int WAIT_STATES_MAX = 15;
  localparam int WAIT_CNT_W      = 4;

  // nM1 low with nIORQ low is an interrupt acknowledge, never an I/O access.
  function automatic cyc_e decodeCycle(input logic nM1, input logic nIORQ,
                                       input logic nRD, input logic nWR);
    cyc_e cyc;
    cyc = CYC_NONE;
    if (!nIORQ) begin
      if (!nM1)             cyc = CYC_ACK;
      else if (!nRD && nWR) cyc = CYC_RD;
      else if (nRD && !nWR) cyc = CYC_WR;
    end
    return cyc;
  endfunction

endpackage

// File: rtl/z80_io_responder_if.sv
// CPU pin-side strobes/address and the local register bus of z80_io_responder.
// The bidirectional data bus D stays a plain inout port on the responder.
interface z80_io_responder_if
  import z80_resp_pkg::*;
#(
  parameter int ADDR_W = 2
);
  logic [15:0]       A;
  logic              nM1;
  logic              nIORQ;
  logic              nRD;
  logic              nWR;
  logic              nWAIT;
  logic              nINT;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [7:0]        reg_rdata;
  logic              irq_req;
  logic [7:0]        irq_vector;

  modport master (
    output A, nM1, nIORQ, nRD, nWR, reg_rdata, irq_req, irq_vector,
    input  nWAIT, nINT, reg_addr, reg_wdata, reg_we, reg_re
  );

  modport slave (
    input  A, nM1, nIORQ, nRD, nWR, reg_rdata, irq_req, irq_vector,
    output nWAIT, nINT, reg_addr, reg_wdata, reg_we, reg_re
  );

endinterface

// File: rtl/z80_io_responder_irq.sv
// Interrupt source for z80_io_responder: irq_req rising-edge detect, pending flag
// and the registered nINT pin. A new edge on the clearing cycle keeps pending set.
module z80_resp_irq (
  input  logic CLK,
  input  logic nRESET,
  input  logic irq_req_i,
  input  logic clear_i,
  output logic pending_o,
  output logic nINT_o
);

  logic irqPrev_q;
  logic pending_q;
  logic pending_d;
  logic nInt_q;
  logic irqRise;

  assign irqRise   = irq_req_i & ~irqPrev_q;
  assign pending_d = irqRise | (pending_q & ~clear_i);

  // irqPrev resets high so a request already asserted at reset is not taken as an edge.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      irqPrev_q <= 1'b1;
      pending_q <= 1'b0;
      nInt_q    <= 1'b1;
    end else begin
      irqPrev_q <= irq_req_i;
      pending_q <= pending_d;
      nInt_q    <= ~pending_d;
    end
  end

  assign pending_o = pending_q;
  assign nINT_o    = nInt_q;

endmodule

// File: rtl/z80_io_responder.sv
// Z80 I/O-space responder: decodes a 2^ADDR_W port window, stretches it with nWAIT and
// answers INTACK. Define Z80_RESP_IM2_VECTOR_EN to drive irq_vector onto D during ACK.
module z80_io_responder
  import z80_resp_pkg::*;
#(
  parameter logic [7:0] BASE_PORT   = 8'h40,
  parameter int         ADDR_W      = 2,
  parameter int         WAIT_STATES = 1
) (
  input  logic              CLK,
  input  logic              nRESET,
  inout  wire  [7:0]        D,
  z80_io_responder_if.slave bus
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
    (WAIT_STATES == 0) ? '0 : WAIT_CNT_W'(WAIT_STATES - 1);

  state_e                  state_q, state_d;
  cyc_e                    cyc;
  logic                    portMatch, ioHit, ackHit, ackClear;
  logic [WAIT_CNT_W-1:0]   waitCnt_q, waitCnt_d;
  logic                    nWait_q;
  logic [ADDR_W-1:0]       regAddr_q;
  logic [7:0]              regWdata_q;
  logic                    regWe_q, regRe_q;
  logic [7:0]              dout_q;
  logic                    doutValid_q, doutIsVec_q;
  logic                    dOe;
  logic                    pending, nInt;
  logic                    unusedAddrHigh;

  assign cyc            = decodeCycle(bus.nM1, bus.nIORQ, bus.nRD, bus.nWR);
  assign portMatch      = (bus.A[7:ADDR_W] == BASE_PORT[7:ADDR_W]);
  assign ioHit          = portMatch && ((cyc == CYC_RD) || (cyc == CYC_WR));
  assign ackHit         = (cyc == CYC_ACK) && pending;
  assign unusedAddrHigh = ^bus.A[15:8];

  // Anything on nIORQ that is not ours parks in HOLD so it is decoded only once.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    ackClear  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ioHit) begin
          state_d   = (WAIT_STATES == 0) ? ACCESS : WAIT;
          waitCnt_d = WAIT_LOAD;
        end else if (ackHit) begin
          state_d = ACK;
        end else if (!bus.nIORQ) begin
          state_d = HOLD;
        end
      end
      WAIT: begin
        if (bus.nIORQ)              state_d = IDLE;
        else if (waitCnt_q == '0)   state_d = ACCESS;
        else                        waitCnt_d = waitCnt_q - 1'b1;
      end
      ACCESS: state_d = HOLD;
      ACK: begin
        state_d  = HOLD;
        ackClear = 1'b1;
      end
      HOLD: if (bus.nIORQ) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q   <= IDLE;
      waitCnt_q <= '0;
      nWait_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      nWait_q   <= (state_d != WAIT);
    end
  end

  // Strobes and latches fire only on the edge that leaves IDLE for a decoded access.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      regAddr_q   <= '0;
      regWdata_q  <= '0;
      regWe_q     <= 1'b0;
      regRe_q     <= 1'b0;
      dout_q      <= '0;
      doutValid_q <= 1'b0;
      doutIsVec_q <= 1'b0;
    end else begin
      regWe_q <= (state_q == IDLE) && ioHit && (cyc == CYC_WR);
      regRe_q <= (state_q == IDLE) && ioHit && (cyc == CYC_RD);
      if ((state_q == IDLE) && ioHit) begin
        regAddr_q <= bus.A[ADDR_W-1:0];
        if (cyc == CYC_WR) regWdata_q <= D;
      end
      if (state_d == IDLE) begin
        doutValid_q <= 1'b0;
        doutIsVec_q <= 1'b0;
      end else if (regRe_q) begin
        dout_q      <= bus.reg_rdata;
        doutValid_q <= 1'b1;
        doutIsVec_q <= 1'b0;
      end
`ifdef Z80_RESP_IM2_VECTOR_EN
      else if (state_q == ACK) begin
        dout_q      <= bus.irq_vector;
        doutValid_q <= 1'b1;
        doutIsVec_q <= 1'b1;
      end
`endif
    end
  end

`ifndef Z80_RESP_IM2_VECTOR_EN
  logic unusedVector;
  assign unusedVector = ^bus.irq_vector;
`endif

  // A read drives while nRD is low; the vector drives while nM1 is low (nRD stays high).
  assign dOe = doutValid_q && !bus.nIORQ && (doutIsVec_q ? !bus.nM1 : !bus.nRD);
  assign D   = dOe ? dout_q : 8'hzz;

  z80_resp_irq u_irq (
    .CLK       (CLK),
    .nRESET    (nRESET),
    .irq_req_i (bus.irq_req),
    .clear_i   (ackClear),
    .pending_o (pending),
    .nINT_o    (nInt)
  );

  assign bus.nWAIT     = nWait_q;
  assign bus.nINT      = nInt;
  assign bus.reg_addr  = regAddr_q;
  assign bus.reg_wdata = regWdata_q;
  assign bus.reg_we    = regWe_q;
  assign bus.reg_re    = regRe_q;

endmodule

// File: tb/tb_z80_io_responder.sv
// Directed bench for z80_io_responder: a WAIT_STATES=1 and a WAIT_STATES=3 instance share
// the same CPU stimulus, each with its own data bus; expectations are hand-computed.
module tb_z80_io_responder;

  logic        CLK = 1'b0;
  logic        nRESET;
  logic [15:0] A;
  logic        nM1, nIORQ, nRD, nWR;
  logic [7:0]  rdata, irqVector;
  logic        irqReq;
  logic [7:0]  cpuD;
  logic        cpuDrive;
  wire  [7:0]  D1, D3;

  int checks   = 0;
  int failures = 0;

`ifdef Z80_RESP_IM2_VECTOR_EN
  localparam logic VEC_EN = 1'b1;
`else
  localparam logic VEC_EN = 1'b0;
`endif

  always #5 CLK = ~CLK;

  assign D1 = cpuDrive ? cpuD : 8'hzz;
  assign D3 = cpuDrive ? cpuD : 8'hzz;

  z80_io_responder_if #(.ADDR_W(2)) bus1 ();
  z80_io_responder_if #(.ADDR_W(2)) bus3 ();

  assign bus1.A = A;          assign bus3.A = A;
  assign bus1.nM1 = nM1;      assign bus3.nM1 = nM1;
  assign bus1.nIORQ = nIORQ;  assign bus3.nIORQ = nIORQ;
  assign bus1.nRD = nRD;      assign bus3.nRD = nRD;
  assign bus1.nWR = nWR;      assign bus3.nWR = nWR;
  assign bus1.reg_rdata = rdata;      assign bus3.reg_rdata = rdata;
  assign bus1.irq_req = irqReq;       assign bus3.irq_req = irqReq;
  assign bus1.irq_vector = irqVector; assign bus3.irq_vector = irqVector;

  z80_io_responder #(.BASE_PORT(8'h40), .ADDR_W(2), .WAIT_STATES(1)) dut1 (
    .CLK(CLK), .nRESET(nRESET), .D(D1), .bus(bus1));

  z80_io_responder #(.BASE_PORT(8'h40), .ADDR_W(2), .WAIT_STATES(3)) dut3 (
    .CLK(CLK), .nRESET(nRESET), .D(D3), .bus(bus3));

  // Running totals sampled mid-cycle; tests take deltas across a scenario.
  int we1Tot = 0, re1Tot = 0, wait1Tot = 0, oe1Tot = 0;
  int we3Tot = 0, re3Tot = 0, wait3Tot = 0, oe3Tot = 0;
  always @(negedge CLK) begin
    if (bus1.reg_we)  we1Tot++;
    if (bus1.reg_re)  re1Tot++;
    if (!bus1.nWAIT)  wait1Tot++;
    if (dut1.dOe)     oe1Tot++;
    if (bus3.reg_we)  we3Tot++;
    if (bus3.reg_re)  re3Tot++;
    if (!bus3.nWAIT)  wait3Tot++;
    if (dut3.dOe)     oe3Tot++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] port, input logic isWrite, input logic [7:0] data);
    A     = {8'h00, port};
    nM1   = 1'b1;
    nIORQ = 1'b0;
    if (isWrite) begin
      nWR = 1'b0; nRD = 1'b1; cpuD = data; cpuDrive = 1'b1;
    end else begin
      nRD = 1'b0; nWR = 1'b1; cpuDrive = 1'b0;
    end
  endtask

  task automatic releaseBus();
    nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1; nM1 = 1'b1; cpuDrive = 1'b0;
  endtask

  task automatic test_reset();
    nRESET = 1'b0;
    tick(2);
    checks++; if (bus1.nWAIT !== 1'b1) begin failures++; $display("[TB] FAIL rst_nwait1 got=%b exp=1", bus1.nWAIT); end
    checks++; if (bus3.nWAIT !== 1'b1) begin failures++; $display("[TB] FAIL rst_nwait3 got=%b exp=1", bus3.nWAIT); end
    checks++; if (bus1.nINT !== 1'b1) begin failures++; $display("[TB] FAIL rst_nint got=%b exp=1", bus1.nINT); end
    checks++; if (bus1.reg_we !== 1'b0 || bus1.reg_re !== 1'b0) begin failures++; $display("[TB] FAIL rst_strobes got=%b%b exp=00", bus1.reg_we, bus1.reg_re); end
    checks++; if (bus1.reg_addr !== 2'd0) begin failures++; $display("[TB] FAIL rst_addr got=%0h exp=0", bus1.reg_addr); end
    checks++; if (bus1.reg_wdata !== 8'h00) begin failures++; $display("[TB] FAIL rst_wdata got=%0h exp=0", bus1.reg_wdata); end
    checks++; if (dut1.dOe !== 1'b0 || dut3.dOe !== 1'b0) begin failures++; $display("[TB] FAIL rst_doe got=%b%b exp=00", dut1.dOe, dut3.dOe); end
    nRESET = 1'b1;
    tick(2);
  endtask

  task automatic test_write();
    int bWe, bWait;
    bWe = we1Tot; bWait = wait1Tot;
    applyStimulus(8'h41, 1'b1, 8'h5A);
    tick(1);
    checks++; if (bus1.reg_we !== 1'b1) begin failures++; $display("[TB] FAIL wr_we_k got=%b exp=1", bus1.reg_we); end
    checks++; if (bus1.nWAIT !== 1'b0) begin failures++; $display("[TB] FAIL wr_nwait_k got=%b exp=0", bus1.nWAIT); end
    tick(1);
    checks++; if (bus1.reg_we !== 1'b0) begin failures++; $display("[TB] FAIL wr_we_k1 got=%b exp=0", bus1.reg_we); end
    checks++; if (bus1.nWAIT !== 1'b1) begin failures++; $display("[TB] FAIL wr_nwait_k1 got=%b exp=1", bus1.nWAIT); end
    tick(2);
    checks++; if (bus1.reg_addr !== 2'd1) begin failures++; $display("[TB] FAIL wr_addr got=%0h exp=1", bus1.reg_addr); end
    checks++; if (bus1.reg_wdata !== 8'h5A) begin failures++; $display("[TB] FAIL wr_wdata got=%0h exp=5a", bus1.reg_wdata); end
    checks++; if (we1Tot - bWe !== 1) begin failures++; $display("[TB] FAIL wr_we_count got=%0d exp=1", we1Tot - bWe); end
    checks++; if (wait1Tot - bWait !== 1) begin failures++; $display("[TB] FAIL wr_wait_cycles got=%0d exp=1", wait1Tot - bWait); end
    releaseBus();
    tick(2);
  endtask

  task automatic test_back_to_back();
    applyStimulus(8'h42, 1'b1, 8'h11);
    tick(4);
    releaseBus();
    tick(1);
    applyStimulus(8'h40, 1'b1, 8'hA5);
    tick(1);
    checks++; if (bus1.reg_we !== 1'b1) begin failures++; $display("[TB] FAIL b2b_we got=%b exp=1", bus1.reg_we); end
    checks++; if (bus1.reg_addr !== 2'd0) begin failures++; $display("[TB] FAIL b2b_addr got=%0h exp=0", bus1.reg_addr); end
    checks++; if (bus1.reg_wdata !== 8'hA5) begin failures++; $display("[TB] FAIL b2b_wdata got=%0h exp=a5", bus1.reg_wdata); end
    tick(3);
    releaseBus();
    tick(3);
  endtask

  task automatic test_read();
    int bRe, bWait;
    rdata = 8'hC3;
    bRe = re3Tot; bWait = wait3Tot;
    applyStimulus(8'h43, 1'b0, 8'h00);
    tick(1);
    checks++; if (bus3.reg_re !== 1'b1) begin failures++; $display("[TB] FAIL rd_re_k got=%b exp=1", bus3.reg_re); end
    checks++; if (bus3.reg_addr !== 2'd3) begin failures++; $display("[TB] FAIL rd_addr got=%0h exp=3", bus3.reg_addr); end
    tick(1);
    checks++; if (dut3.dOe !== 1'b1 || D3 !== 8'hC3) begin failures++; $display("[TB] FAIL rd_data_k1 got=oe%b/%0h exp=oe1/c3", dut3.dOe, D3); end
    checks++; if (bus3.nWAIT !== 1'b0) begin failures++; $display("[TB] FAIL rd_nwait_k1 got=%b exp=0", bus3.nWAIT); end
    tick(3);
    checks++; if (re3Tot - bRe !== 1) begin failures++; $display("[TB] FAIL rd_re_count got=%0d exp=1", re3Tot - bRe); end
    checks++; if (wait3Tot - bWait !== 3) begin failures++; $display("[TB] FAIL rd_wait_cycles got=%0d exp=3", wait3Tot - bWait); end
    checks++; if (D3 !== 8'hC3) begin failures++; $display("[TB] FAIL rd_data_hold got=%0h exp=c3", D3); end
    nRD = 1'b1;
    #1;
    checks++; if (dut3.dOe !== 1'b0) begin failures++; $display("[TB] FAIL rd_release got=%b exp=0", dut3.dOe); end
    releaseBus();
    tick(3);
  endtask

  task automatic test_nomatch();
    int bRe1, bRe3, bWait1, bWait3, bOe3;
    bRe1 = re1Tot; bRe3 = re3Tot; bWait1 = wait1Tot; bWait3 = wait3Tot; bOe3 = oe3Tot;
    applyStimulus(8'h80, 1'b0, 8'h00);
    tick(5);
    checks++; if (re1Tot - bRe1 !== 0 || re3Tot - bRe3 !== 0) begin failures++; $display("[TB] FAIL nm_re got=%0d/%0d exp=0/0", re1Tot - bRe1, re3Tot - bRe3); end
    checks++; if (wait1Tot - bWait1 !== 0 || wait3Tot - bWait3 !== 0) begin failures++; $display("[TB] FAIL nm_wait got=%0d/%0d exp=0/0", wait1Tot - bWait1, wait3Tot - bWait3); end
    checks++; if (oe3Tot - bOe3 !== 0) begin failures++; $display("[TB] FAIL nm_drive got=%0d exp=0", oe3Tot - bOe3); end
    releaseBus();
    tick(2);
  endtask

  task automatic test_interrupt();
    int bWait3;
    irqVector = 8'h20;
    irqReq = 1'b1;
    tick(2);
    checks++; if (bus3.nINT !== 1'b0) begin failures++; $display("[TB] FAIL int_nint_set got=%b exp=0", bus3.nINT); end
    bWait3 = wait3Tot;
    nM1 = 1'b0; nIORQ = 1'b0;
    tick(1);
    checks++; if (bus3.nINT !== 1'b0) begin failures++; $display("[TB] FAIL int_nint_k got=%b exp=0", bus3.nINT); end
    tick(1);
    checks++; if (bus3.nINT !== 1'b1) begin failures++; $display("[TB] FAIL int_nint_k1 got=%b exp=1", bus3.nINT); end
    checks++; if (dut3.dOe !== VEC_EN) begin failures++; $display("[TB] FAIL int_vec_oe got=%b exp=%b", dut3.dOe, VEC_EN); end
    checks++; if ((dut3.dOe ? D3 : 8'hFF) !== (VEC_EN ? 8'h20 : 8'hFF)) begin failures++; $display("[TB] FAIL int_vec_data got=%0h exp=%0h", dut3.dOe ? D3 : 8'hFF, VEC_EN ? 8'h20 : 8'hFF); end
    tick(1);
    releaseBus();
    tick(2);
    checks++; if (wait3Tot - bWait3 !== 0) begin failures++; $display("[TB] FAIL int_no_wait got=%0d exp=0", wait3Tot - bWait3); end
  endtask

  task automatic test_simultaneous();
    irqReq = 1'b0;
    tick(1);
    irqReq = 1'b1;
    tick(2);
    checks++; if (bus3.nINT !== 1'b0) begin failures++; $display("[TB] FAIL sim_nint_set got=%b exp=0", bus3.nINT); end
    irqReq = 1'b0;
    tick(2);
    nM1 = 1'b0; nIORQ = 1'b0;
    tick(1);
    irqReq = 1'b1;
    tick(1);
    checks++; if (bus3.nINT !== 1'b0) begin failures++; $display("[TB] FAIL sim_nint_k1 got=%b exp=0", bus3.nINT); end
    releaseBus();
    tick(3);
    checks++; if (bus3.nINT !== 1'b0) begin failures++; $display("[TB] FAIL sim_pending_kept got=%b exp=0", bus3.nINT); end
    nM1 = 1'b0; nIORQ = 1'b0;
    tick(2);
    checks++; if (bus3.nINT !== 1'b1) begin failures++; $display("[TB] FAIL sim_second_ack got=%b exp=1", bus3.nINT); end
    releaseBus();
    tick(2);
  endtask

  task automatic test_abort();
    int bWait3, bOe3, bRe3;
    rdata = 8'h77;
    bWait3 = wait3Tot; bOe3 = oe3Tot;
    applyStimulus(8'h42, 1'b0, 8'h00);
    tick(1);
    checks++; if (bus3.reg_re !== 1'b1) begin failures++; $display("[TB] FAIL ab_re_k got=%b exp=1", bus3.reg_re); end
    tick(1);
    releaseBus();
    bRe3 = re3Tot;
    tick(1);
    checks++; if (bus3.nWAIT !== 1'b1) begin failures++; $display("[TB] FAIL ab_nwait got=%b exp=1", bus3.nWAIT); end
    tick(4);
    checks++; if (re3Tot - bRe3 !== 0) begin failures++; $display("[TB] FAIL ab_no_re got=%0d exp=0", re3Tot - bRe3); end
    checks++; if (wait3Tot - bWait3 !== 2) begin failures++; $display("[TB] FAIL ab_wait_cycles got=%0d exp=2", wait3Tot - bWait3); end
    checks++; if (oe3Tot - bOe3 !== 0) begin failures++; $display("[TB] FAIL ab_drive got=%0d exp=0", oe3Tot - bOe3); end
  endtask

  task automatic test_reset_mid_read();
    int bRe3, bWait3;
    rdata = 8'hC3;
    applyStimulus(8'h41, 1'b0, 8'h00);
    tick(2);
    checks++; if (dut3.dOe !== 1'b1) begin failures++; $display("[TB] FAIL mr_pre_drive got=%b exp=1", dut3.dOe); end
    #2;
    nRESET = 1'b0;
    #1;
    checks++; if (dut3.dOe !== 1'b0) begin failures++; $display("[TB] FAIL mr_release got=%b exp=0", dut3.dOe); end
    checks++; if (bus3.nWAIT !== 1'b1) begin failures++; $display("[TB] FAIL mr_nwait got=%b exp=1", bus3.nWAIT); end
    checks++; if (bus3.reg_addr !== 2'd0) begin failures++; $display("[TB] FAIL mr_addr got=%0h exp=0", bus3.reg_addr); end
    releaseBus();
    tick(1);
    nRESET = 1'b1;
    tick(1);
    rdata = 8'h3C;
    bRe3 = re3Tot; bWait3 = wait3Tot;
    applyStimulus(8'h41, 1'b0, 8'h00);
    tick(2);
    checks++; if (dut3.dOe !== 1'b1 || D3 !== 8'h3C) begin failures++; $display("[TB] FAIL mr_next_data got=oe%b/%0h exp=oe1/3c", dut3.dOe, D3); end
    checks++; if (bus3.reg_addr !== 2'd1) begin failures++; $display("[TB] FAIL mr_next_addr got=%0h exp=1", bus3.reg_addr); end
    tick(3);
    checks++; if (re3Tot - bRe3 !== 1) begin failures++; $display("[TB] FAIL mr_next_re got=%0d exp=1", re3Tot - bRe3); end
    checks++; if (wait3Tot - bWait3 !== 3) begin failures++; $display("[TB] FAIL mr_next_wait got=%0d exp=3", wait3Tot - bWait3); end
    releaseBus();
    tick(3);
  endtask

  initial begin
    nRESET = 1'b0;
    A = 16'h0000; rdata = 8'h00; irqReq = 1'b0; irqVector = 8'h00; cpuD = 8'h00;
    releaseBus();
    $display("[TB] start, vector drive enabled=%b", VEC_EN);
    test_reset();
    test_write();
    test_back_to_back();
    test_read();
    test_nomatch();
    test_interrupt();
    test_simultaneous();
    test_abort();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
